// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the byte FIFO used by the UART receiver.
package fifo_pkg;
   localparam int DEFAULT_DEPTH = 4;
   localparam int DEFAULT_WIDTH = 8;

   function automatic bit is_pow2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction
endpackage

// File: rtl/fifo_if.sv
// Producer/consumer handshake bundle of the FIFO; names are as seen from the FIFO itself.
interface fifo_if import fifo_pkg::*; #(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int WIDTH = DEFAULT_WIDTH
) ();
   logic                     i_write;
   logic [WIDTH-1:0]         i_wdata;
   logic                     i_read;
   logic [WIDTH-1:0]         o_rdata;
   logic                     o_empty;
   logic                     o_full;
   logic [$clog2(DEPTH):0]   o_count;

   modport master (output i_write, i_wdata, i_read,
                   input  o_rdata, o_empty, o_full, o_count);
   modport slave  (input  i_write, i_wdata, i_read,
                   output o_rdata, o_empty, o_full, o_count);
endinterface

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH storage: one synchronous write port, one registered read port.
// The array itself is never reset; only the read register is.
module fifo_mem import fifo_pkg::*; #(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic                       i_wen,
   input  logic [$clog2(DEPTH)-1:0]   i_waddr,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_ren,
   input  logic [$clog2(DEPTH)-1:0]   i_raddr,
   output logic [WIDTH-1:0]           o_rdata
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge i_clock) begin
      if (i_wen) r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset)    r_rdata <= '0;
      else if (i_ren) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/fifo.sv
// Single-clock FIFO: pointers, occupancy count and flags; storage lives in fifo_mem.
// Flags decode the registered count only, so nothing combinational runs from i_write/i_read.
module fifo import fifo_pkg::*; #(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic    i_clock,
   input  logic    i_reset,
   fifo_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (!is_pow2(DEPTH)) begin : g_depth_check
      $error("fifo: DEPTH must be a power of two and at least 2");
   end

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_wr_acc;
   logic          w_rd_acc;
   logic          w_full;

   assign w_full   = (r_count == CW'(DEPTH));
   assign w_rd_acc = bus.i_read && (r_count != '0);
   // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
   assign w_wr_acc = bus.i_write && (!w_full || w_rd_acc);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_wen   (w_wr_acc),
      .i_waddr (r_wr_ptr),
      .i_wdata (bus.i_wdata),
      .i_ren   (w_rd_acc),
      .i_raddr (r_rd_ptr),
      .o_rdata (bus.o_rdata)
   );

   assign bus.o_empty = (r_count == '0);
   assign bus.o_full  = w_full;
   assign bus.o_count = r_count;
endmodule

// File: tb/tb_fifo.sv
// Bench for fifo: directed vector table, a held-read sequence, then random traffic vs a queue model.
module tb_fifo;
   localparam int DEPTH = 4;
   localparam int WIDTH = 8;

   logic i_clock = 1'b0;
   logic i_reset;
   always #5 i_clock = ~i_clock;

   fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

   fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_dut (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .bus     (bus)
   );

   typedef struct {
      logic       rst;
      logic       wr;
      logic       rd;
      logic [7:0] wdata;
      logic [7:0] e_rdata;
      logic       e_empty;
      logic       e_full;
      logic [2:0] e_count;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   // model state for random phase
   logic [7:0] m_q[$];
   logic [7:0] m_rdata;

   function automatic void add(input logic rst, wr, rd, input logic [7:0] wd,
                               input logic [7:0] rdat, input logic emp, ful,
                               input logic [2:0] cnt);
      vec_t v;
      v.rst = rst; v.wr = wr; v.rd = rd; v.wdata = wd;
      v.e_rdata = rdat; v.e_empty = emp; v.e_full = ful; v.e_count = cnt;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
      end
   endtask

   task automatic step(input logic rst, wr, rd, input logic [7:0] wd);
      @(negedge i_clock);
      i_reset     = rst;
      bus.i_write = wr;
      bus.i_read  = rd;
      bus.i_wdata = wd;
      @(posedge i_clock);
      #1;
   endtask

   task automatic chk_all(input string tag, input int idx, input logic [7:0] rdat,
                          input logic emp, ful, input logic [2:0] cnt);
      chk({tag, "_rdata"}, idx, 32'(bus.o_rdata), 32'(rdat));
      chk({tag, "_empty"}, idx, 32'(bus.o_empty), 32'(emp));
      chk({tag, "_full"},  idx, 32'(bus.o_full),  32'(ful));
      chk({tag, "_count"}, idx, 32'(bus.o_count), 32'(cnt));
   endtask

   initial begin
      i_reset = 1'b1; bus.i_write = 1'b0; bus.i_read = 1'b0; bus.i_wdata = '0;

      //   rst wr rd wdata  rdata  emp ful cnt
      add(1, 0, 0, 8'h00, 8'h00, 1, 0, 0);
      add(1, 0, 0, 8'h00, 8'h00, 1, 0, 0);
      add(0, 1, 0, 8'hA5, 8'h00, 0, 0, 1);
      add(0, 0, 1, 8'h00, 8'hA5, 1, 0, 0);
      add(0, 1, 0, 8'h01, 8'hA5, 0, 0, 1);
      add(0, 1, 0, 8'h02, 8'hA5, 0, 0, 2);
      add(0, 1, 0, 8'h03, 8'hA5, 0, 0, 3);
      add(0, 1, 0, 8'h04, 8'hA5, 0, 1, 4);
      add(0, 1, 0, 8'h05, 8'hA5, 0, 1, 4);
      add(0, 0, 1, 8'h00, 8'h01, 0, 0, 3);
      add(0, 0, 1, 8'h00, 8'h02, 0, 0, 2);
      add(0, 0, 1, 8'h00, 8'h03, 0, 0, 1);
      add(0, 0, 1, 8'h00, 8'h04, 1, 0, 0);
      add(0, 0, 1, 8'h00, 8'h04, 1, 0, 0);
      add(0, 1, 0, 8'h31, 8'h04, 0, 0, 1);
      add(0, 1, 0, 8'h32, 8'h04, 0, 0, 2);
      add(0, 1, 0, 8'h33, 8'h04, 0, 0, 3);
      add(0, 0, 1, 8'h00, 8'h31, 0, 0, 2);
      add(0, 0, 1, 8'h00, 8'h32, 0, 0, 1);
      add(0, 0, 1, 8'h00, 8'h33, 1, 0, 0);
      add(0, 1, 0, 8'h10, 8'h33, 0, 0, 1);
      add(0, 1, 0, 8'h11, 8'h33, 0, 0, 2);
      add(0, 1, 0, 8'h12, 8'h33, 0, 0, 3);
      add(0, 1, 0, 8'h13, 8'h33, 0, 1, 4);
      add(0, 1, 1, 8'h20, 8'h10, 0, 1, 4);
      add(0, 0, 1, 8'h00, 8'h11, 0, 0, 3);
      add(0, 0, 1, 8'h00, 8'h12, 0, 0, 2);
      add(0, 0, 1, 8'h00, 8'h13, 0, 0, 1);
      add(0, 0, 1, 8'h00, 8'h20, 1, 0, 0);
      add(0, 1, 1, 8'h44, 8'h20, 0, 0, 1);
      add(0, 1, 0, 8'h55, 8'h20, 0, 0, 2);
      add(1, 1, 1, 8'h77, 8'h00, 1, 0, 0);
      add(0, 1, 0, 8'h66, 8'h00, 0, 0, 1);
      add(0, 0, 1, 8'h00, 8'h66, 1, 0, 0);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].wdata);
         chk_all("vec", i, vecs[i].e_rdata, vecs[i].e_empty, vecs[i].e_full, vecs[i].e_count);
      end

      // i_read held high: one pop per cycle, then holds once empty
      step(0, 1, 0, 8'h71);
      step(0, 1, 0, 8'h72);
      step(0, 1, 0, 8'h73);
      chk_all("hold_fill", 0, 8'h66, 0, 0, 3);
      step(0, 0, 1, 8'h00); chk_all("hold", 1, 8'h71, 0, 0, 2);
      step(0, 0, 1, 8'h00); chk_all("hold", 2, 8'h72, 0, 0, 1);
      step(0, 0, 1, 8'h00); chk_all("hold", 3, 8'h73, 1, 0, 0);
      step(0, 0, 1, 8'h00); chk_all("hold", 4, 8'h73, 1, 0, 0);

      // random traffic against a queue model
      step(1, 0, 0, 8'h00);
      m_q.delete();
      m_rdata = '0;
      chk_all("rnd_rst", 0, m_rdata, 1, 0, 0);
      for (int n = 1; n <= 3000; n++) begin
         logic r_rst, r_wr, r_rd, rd_ok, wr_ok;
         logic [7:0] r_wd;
         int pw, pr;
         pw = ((n / 250) % 2 == 0) ? 70 : 35;
         pr = ((n / 250) % 2 == 0) ? 35 : 70;
         r_rst = ($urandom_range(0, 99) == 0);
         r_wr  = ($urandom_range(0, 99) < pw);
         r_rd  = ($urandom_range(0, 99) < pr);
         r_wd  = 8'($urandom);
         step(r_rst, r_wr, r_rd, r_wd);
         if (r_rst) begin
            m_q.delete();
            m_rdata = '0;
         end else begin
            rd_ok = r_rd && (m_q.size() > 0);
            wr_ok = r_wr && ((m_q.size() < DEPTH) || rd_ok);
            if (rd_ok) m_rdata = m_q.pop_front();
            if (wr_ok) m_q.push_back(r_wd);
         end
         chk_all("rnd", n, m_rdata, m_q.size() == 0, m_q.size() == DEPTH, 3'(m_q.size()));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
